// File: rtl/render_sequencer_if.sv
// Handshake bundle between the render sequencer and the ball renderer.
// Master = sequencer (drives phase levels); slave = renderer (returns done strobes).
interface render_sequencer_if;
    logic clearOld_pulse;
    logic drawNew_pulse;
    logic blackScreen_pulse;
    logic done_clearOld;
    logic done_drawNew;
    logic done_blackScreen;

    modport master (
        output clearOld_pulse, drawNew_pulse, blackScreen_pulse,
        input  done_clearOld, done_drawNew, done_blackScreen
    );

    modport slave (
        input  clearOld_pulse, drawNew_pulse, blackScreen_pulse,
        output done_clearOld, done_drawNew, done_blackScreen
    );
endinterface

// File: rtl/render_sequencer.sv
// Frame render sequencer: black -> settle -> idle -> clear -> draw; outputs are decoded from state, transitions land on the sampling edge.
// Stalls whole-sequencer on enable=0; optional phase watchdog under PONG_RENDER_TIMEOUT_EN.
module render_sequencer #(
    parameter int TIMEOUT_CYCLES = 'd4096,
    parameter int MISS_W         = 'd8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 frameTick,
    input  logic                 lhs_scored,
    input  logic                 rhs_scored,
    render_sequencer_if.master   rnd,
    output logic                 move_enable,
    output logic                 frame_busy,
    output logic [MISS_W-1:0]    missed_frames,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        S_BLACK  = 3'd0,
        S_SETTLE = 3'd1,
        S_IDLE   = 3'd2,
        S_CLEAR  = 3'd3,
        S_DRAW   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_pending;
    logic [MISS_W-1:0]   r_missed;
    logic                w_scored;
    logic                w_timeout;
    logic                w_in_phase;

    assign w_scored   = lhs_scored | rhs_scored;
    assign w_in_phase = (r_state == S_BLACK) || (r_state == S_CLEAR) || (r_state == S_DRAW);

`ifdef PONG_RENDER_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] r_wdog;
    logic            r_timeout_err;

    assign w_timeout   = w_in_phase && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;

    // Count restarts on any state change and on a timeout, including one in S_BLACK.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else if (enable) begin
            if (w_timeout || (w_next != r_state) || !w_in_phase)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + 1'b1;
            if (w_timeout)
                r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_BLACK;
        else if (enable)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BLACK:  if (rnd.done_blackScreen) w_next = S_SETTLE;
            S_SETTLE: if (!lhs_scored && !rhs_scored) w_next = S_IDLE;
            S_IDLE: begin
                // A pending score pre-empts a same-cycle frameTick, which is simply dropped.
                if (r_pending)      w_next = S_BLACK;
                else if (frameTick) w_next = S_CLEAR;
            end
            S_CLEAR:  if (rnd.done_clearOld) w_next = S_DRAW;
            S_DRAW:   if (rnd.done_drawNew) w_next = r_pending ? S_BLACK : S_IDLE;
            default:  w_next = S_BLACK;
        endcase
        if (w_timeout)
            w_next = S_BLACK;
    end

    always_comb begin
        rnd.blackScreen_pulse = 1'b0;
        rnd.clearOld_pulse    = 1'b0;
        rnd.drawNew_pulse     = 1'b0;
        move_enable           = 1'b0;
        frame_busy            = (r_state != S_IDLE);
        case (r_state)
            S_BLACK: rnd.blackScreen_pulse = 1'b1;
            S_CLEAR: rnd.clearOld_pulse    = 1'b1;
            S_DRAW:  rnd.drawNew_pulse     = 1'b1;
            S_IDLE:  move_enable           = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pending <= 1'b0;
        end else if (enable) begin
            if ((w_next == S_BLACK) && (r_state != S_BLACK))
                r_pending <= 1'b0;
            else if (w_scored && ((r_state == S_IDLE) || (r_state == S_CLEAR) || (r_state == S_DRAW)))
                r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_missed <= '0;
        else if (enable && frameTick && (r_state != S_IDLE) && (r_missed != {MISS_W{1'b1}}))
            r_missed <= r_missed + 1'b1;
    end

    assign missed_frames = r_missed;

endmodule

// File: tb/tb_render_sequencer.sv
// Directed bench for render_sequencer: sequencing, scoring, missed-frame count, freeze, reset, watchdog.
module tb_render_sequencer;

    localparam logic [4:0] ST_BLACK  = 5'b10001;
    localparam logic [4:0] ST_SETTLE = 5'b00001;
    localparam logic [4:0] ST_IDLE   = 5'b00010;
    localparam logic [4:0] ST_CLEAR  = 5'b01001;
    localparam logic [4:0] ST_DRAW   = 5'b00101;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       frameTick;
    logic       lhs_scored;
    logic       rhs_scored;
    logic       move_enable;
    logic       frame_busy;
    logic [7:0] missed_frames;
    logic       timeout_err;
    logic       wd_move_enable;
    logic       wd_frame_busy;
    logic [7:0] wd_missed_frames;
    logic       wd_timeout_err;

    int n_cmp;
    int n_err;
    int cnt;

    render_sequencer_if rif();
    render_sequencer_if wif();

    assign wif.done_clearOld    = rif.done_clearOld;
    assign wif.done_drawNew     = rif.done_drawNew;
    assign wif.done_blackScreen = rif.done_blackScreen;

    render_sequencer #(.TIMEOUT_CYCLES(4096), .MISS_W(8)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .frameTick     (frameTick),
        .lhs_scored    (lhs_scored),
        .rhs_scored    (rhs_scored),
        .rnd           (rif.master),
        .move_enable   (move_enable),
        .frame_busy    (frame_busy),
        .missed_frames (missed_frames),
        .timeout_err   (timeout_err)
    );

    render_sequencer #(.TIMEOUT_CYCLES(16), .MISS_W(8)) dut_wd (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .frameTick     (frameTick),
        .lhs_scored    (lhs_scored),
        .rhs_scored    (rhs_scored),
        .rnd           (wif.master),
        .move_enable   (wd_move_enable),
        .frame_busy    (wd_frame_busy),
        .missed_frames (wd_missed_frames),
        .timeout_err   (wd_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] st_main();
        return {rif.blackScreen_pulse, rif.clearOld_pulse, rif.drawNew_pulse, move_enable, frame_busy};
    endfunction

    function automatic logic [4:0] st_wd();
        return {wif.blackScreen_pulse, wif.clearOld_pulse, wif.drawNew_pulse, wd_move_enable, wd_frame_busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn = 1'b0;
        enable = 1'b1;
        frameTick = 1'b0;
        lhs_scored = 1'b0;
        rhs_scored = 1'b0;
        rif.done_clearOld = 1'b0;
        rif.done_drawNew = 1'b0;
        rif.done_blackScreen = 1'b0;
        #3;
        check("reset_state", 32'(st_main()), 32'(ST_BLACK));
        check("reset_missed", 32'(missed_frames), 32'd0);
        check("reset_timeout", 32'(timeout_err), 32'd0);

        // Release, then done_blackScreen at cycle 5.
        step();
        resetn = 1'b1;
        repeat (4) step();
        check("black_hold", 32'(st_main()), 32'(ST_BLACK));
        rif.done_blackScreen = 1'b1;
        step();
        rif.done_blackScreen = 1'b0;
        check("to_settle", 32'(st_main()), 32'(ST_SETTLE));
        step();
        check("to_idle", 32'(st_main()), 32'(ST_IDLE));

        // Stray done strobe in IDLE.
        rif.done_drawNew = 1'b1;
        step();
        rif.done_drawNew = 1'b0;
        check("idle_ignore_done", 32'(st_main()), 32'(ST_IDLE));

        // Frame 1: clean clear/draw of 20 cycles each.
        frameTick = 1'b1;
        step();
        frameTick = 1'b0;
        check("tick_to_clear", 32'(st_main()), 32'(ST_CLEAR));
        cnt = 1;
        for (int i = 0; i < 19; i++) begin
            step();
            if (rif.clearOld_pulse) cnt++;
        end
        rif.done_clearOld = 1'b1;
        step();
        rif.done_clearOld = 1'b0;
        check("clear_cycles", 32'(cnt), 32'd20);
        check("to_draw", 32'(st_main()), 32'(ST_DRAW));
        cnt = 1;
        for (int i = 0; i < 19; i++) begin
            step();
            if (rif.drawNew_pulse) cnt++;
        end
        rif.done_drawNew = 1'b1;
        step();
        rif.done_drawNew = 1'b0;
        check("draw_cycles", 32'(cnt), 32'd20);
        check("draw_to_idle", 32'(st_main()), 32'(ST_IDLE));
        check("frame1_missed", 32'(missed_frames), 32'd0);

        // Frame 2: score during CLEAR, dropped ticks in DRAW, freeze window.
        frameTick = 1'b1;
        step();
        frameTick = 1'b0;
        rhs_scored = 1'b1;
        repeat (3) step();
        rif.done_clearOld = 1'b1;
        step();
        rif.done_clearOld = 1'b0;
        check("f2_draw", 32'(st_main()), 32'(ST_DRAW));
        for (int i = 0; i < 3; i++) begin
            frameTick = 1'b1;
            step();
            frameTick = 1'b0;
            step();
        end
        check("missed_three", 32'(missed_frames), 32'd3);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rif.done_drawNew = (i == 4);
            frameTick = (i == 6);
            step();
        end
        rif.done_drawNew = 1'b0;
        frameTick = 1'b0;
        enable = 1'b1;
        check("freeze_state", 32'(st_main()), 32'(ST_DRAW));
        check("freeze_missed", 32'(missed_frames), 32'd3);
        rif.done_drawNew = 1'b1;
        step();
        rif.done_drawNew = 1'b0;
        check("score_to_black", 32'(st_main()), 32'(ST_BLACK));
        rif.done_blackScreen = 1'b1;
        step();
        rif.done_blackScreen = 1'b0;
        repeat (3) step();
        check("settle_hold", 32'(st_main()), 32'(ST_SETTLE));
        rhs_scored = 1'b0;
        step();
        check("settle_release", 32'(st_main()), 32'(ST_IDLE));

        // Pending score beats a same-cycle frameTick, which is not counted.
        lhs_scored = 1'b1;
        step();
        lhs_scored = 1'b0;
        frameTick = 1'b1;
        step();
        frameTick = 1'b0;
        check("pending_wins", 32'(st_main()), 32'(ST_BLACK));
        check("pending_tick_drop", 32'(missed_frames), 32'd3);

        // Get to DRAW, then reset asynchronously mid-phase.
        rif.done_blackScreen = 1'b1;
        step();
        rif.done_blackScreen = 1'b0;
        step();
        frameTick = 1'b1;
        step();
        frameTick = 1'b0;
        rif.done_clearOld = 1'b1;
        step();
        rif.done_clearOld = 1'b0;
        check("pre_reset_draw", 32'(st_main()), 32'(ST_DRAW));
        resetn = 1'b0;
        #2;
        check("async_reset_state", 32'(st_main()), 32'(ST_BLACK));
        check("async_reset_missed", 32'(missed_frames), 32'd0);

        // Saturation: 300 ticks outside IDLE.
        step();
        resetn = 1'b1;
        frameTick = 1'b1;
        repeat (300) step();
        frameTick = 1'b0;
        check("missed_saturate", 32'(missed_frames), 32'd255);

        // Watchdog: 16-cycle limit on the second instance, stalled in CLEAR.
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        rif.done_blackScreen = 1'b1;
        step();
        rif.done_blackScreen = 1'b0;
        step();
        frameTick = 1'b1;
        step();
        frameTick = 1'b0;
        check("wd_in_clear", 32'(st_wd()), 32'(ST_CLEAR));
        repeat (15) step();
        check("wd_clear_15", 32'(st_wd()), 32'(ST_CLEAR));
        check("wd_err_15", 32'(wd_timeout_err), 32'd0);
        step();
`ifdef PONG_RENDER_TIMEOUT_EN
        check("wd_forced_black", 32'(st_wd()), 32'(ST_BLACK));
        check("wd_err_set", 32'(wd_timeout_err), 32'd1);
`else
        repeat (30) step();
        check("wd_clear_held", 32'(st_wd()), 32'(ST_CLEAR));
        check("wd_err_zero", 32'(wd_timeout_err), 32'd0);
`endif
        check("main_no_timeout", 32'(timeout_err), 32'd0);
        check("main_still_clear", 32'(st_main()), 32'(ST_CLEAR));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/render_sequencer.md
RENDER_SEQUENCER -- requirements
Module: render_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 'd4096, meaning the watchdog limit in clk cycles for any one render phase.
REQ-002 Parameter MISS_W, default 'd8, meaning the width of the missed-frame counter.
REQ-003 clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  high = sequencer runs; low = all state, counters and outputs are frozen.
REQ-006 frameTick  input  1  one-cycle frame strobe from the rate divider.
REQ-007 lhs_scored, rhs_scored  input  1 each  score levels from ball control.
REQ-008 done_clearOld, done_drawNew, done_blackScreen  input  1 each  phase-complete strobes from the ball renderer.
REQ-009 clearOld_pulse, drawNew_pulse, blackScreen_pulse  output  1 each  phase-active levels to the ball renderer.
REQ-010 move_enable  output  1  enable for ball physics.
REQ-011 frame_busy  output  1  high in any state other than S_IDLE.
REQ-012 missed_frames  output  MISS_W  saturating count of dropped frameTicks.
REQ-013 timeout_err  output  1  sticky watchdog flag.

Function
REQ-014 States SHALL be S_BLACK, S_SETTLE, S_IDLE, S_CLEAR and S_DRAW; all outputs SHALL be decoded from registered state and counters only.
REQ-015 Decode: blackScreen_pulse=1 only in S_BLACK, clearOld_pulse=1 only in S_CLEAR, drawNew_pulse=1 only in S_DRAW, and move_enable=1 only in S_IDLE; at most one phase level SHALL be high at any time.
REQ-016 S_BLACK -> S_SETTLE on done_blackScreen.
REQ-017 S_SETTLE -> S_IDLE in the first cycle with lhs_scored=0 and rhs_scored=0; otherwise the FSM stays in S_SETTLE.
REQ-018 S_IDLE -> S_BLACK if score_pending=1; else S_IDLE -> S_CLEAR on frameTick; score_pending wins when both occur in the same cycle, and that frameTick is discarded without being counted.
REQ-019 S_CLEAR -> S_DRAW on done_clearOld.
REQ-020 S_DRAW -> S_BLACK on done_drawNew with score_pending=1; S_DRAW -> S_IDLE on done_drawNew with score_pending=0.
REQ-021 Latency: frameTick sampled high at edge N in S_IDLE SHALL give clearOld_pulse=1 and move_enable=0 from edge N onward.
REQ-022 score_pending SHALL be set when (lhs_scored|rhs_scored)=1 in S_IDLE, S_CLEAR or S_DRAW, and SHALL be cleared on entry to S_BLACK.
REQ-023 done strobes not matching the current state SHALL be ignored.
REQ-024 frameTick=1 in any state except S_IDLE SHALL increment missed_frames, which saturates at all-ones and is cleared only by reset.
REQ-025 enable=0 SHALL freeze state, score_pending, missed_frames and the watchdog; inputs are not sampled during that time.

Reset
REQ-026 resetn=0 SHALL immediately, without a clock, set state=S_BLACK, score_pending=0, missed_frames=0, watchdog=0 and timeout_err=0.
REQ-027 Outputs during reset SHALL be blackScreen_pulse=1, all other phase levels 0, move_enable=0 and frame_busy=1.
REQ-028 Reset asserted mid-phase SHALL abandon that phase; the first phase after release SHALL be S_BLACK.

Configuration
REQ-029 Macro PONG_RENDER_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-030 With the macro, a counter SHALL count enabled cycles spent in S_BLACK, S_CLEAR or S_DRAW, and SHALL clear on every state change.
REQ-031 With the macro, reaching TIMEOUT_CYCLES-1 SHALL set timeout_err and force S_BLACK, restarting the counter; a timeout while already in S_BLACK SHALL only set the flag and restart the count.
REQ-032 Without the macro, timeout_err SHALL be constant 0, no counter logic SHALL exist, and phases SHALL wait indefinitely.

Verification
REQ-033 Release reset with done_blackScreen pulsed at cycle 5 and scores low -> S_SETTLE at cycle 6, S_IDLE at cycle 7, move_enable=1.
REQ-034 In S_IDLE, frameTick, then done_clearOld 20 cycles later, then done_drawNew 20 cycles after that -> clearOld_pulse high for 20 cycles, drawNew_pulse high for 20 cycles, then S_IDLE with missed_frames=0.
REQ-035 rhs_scored=1 during S_CLEAR -> after done_drawNew the FSM enters S_BLACK; it stays in S_SETTLE until rhs_scored=0.
REQ-036 3 frameTicks during S_DRAW, plus 300 frameTicks in a separate run with MISS_W=8 -> missed_frames=3 in the first case and 255 (saturated) in the second.
REQ-037 Macro defined, TIMEOUT_CYCLES=16, no done_clearOld -> timeout_err=1 and S_BLACK after 16 cycles in S_CLEAR; macro undefined -> S_CLEAR held and timeout_err=0.
REQ-038 enable=0 for 10 cycles mid-S_DRAW with done_drawNew pulsed in that window -> state unchanged and the strobe ignored; resetn=0 mid-S_DRAW -> blackScreen_pulse=1 with no clock edge.
